serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor: accepts two WIDTH-bit operands on a start/ready handshake and computes one result bit per clock, LSB first. A single gate-level full-adder cell plus a carry flip-flop does the work, so WIDTH-bit operands cost WIDTH cycles instead of WIDTH adder cells. It is the sequential, multi-bit successor to the gate-level adder primitives in the arithmetic library. It serves area-constrained datapaths where throughput is not critical.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder_full_adder_cell.sv | 19 +
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

  // State encodings, kept as named constants so the enum and any debug
  // tooling agree on the bit patterns.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operands, observes the result.
  modport master (
    output start, a, b, cin, sub,
    input  ready, done, sum, cout, ovf
  );

  // Adder side: consumes operands, produces the result.
  modport slave (
    input  start, a, b, cin, sub,
    output ready, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from gate primitives: two half-adder stages
// (XOR/AND each) with an OR merging the two partial carries.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  wire p;
  wire g1;
  wire g2;

  xor u_x1 (p, a, b);
  and u_a1 (g1, a, b);
  xor u_x2 (s, p, ci);
  and u_a2 (g2, p, ci);
  or  u_o1 (co, g1, g2);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// the operands LSB first, one bit per clock, over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, finish after the last bit, one DONE cycle.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)     state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.done  = (state_q == DONE);
  end

  // Datapath next values: operand load on accept, shift/accumulate in RUN,
  // result registers updated only on the final bit.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && bus.start) begin
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_co;
      if (cnt_q == LAST) begin
        sum_d  = {fa_s, res_q[WIDTH-1:1]};
        cout_d = fa_co;
        // carry_q is the carry into the MSB during the last bit.
        ovf_d  = carry_q ^ fa_co;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, shifters included, is reset so an aborted
    // operation leaves no stale state behind.
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations filled in by do_op.
  logic [7:0] obs_sum;
  logic       obs_cout;
  logic       obs_ovf;
  logic [7:0] obs_mid_sum;
  int         obs_done_cnt;
  int         obs_done_lat;
  int         obs_ready_lat;
  logic       obs_timeout;

  // Drive one operation and record what happens; no judgement here.
  // pulse_at > 0 raises start with different operands at that cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input int pulse_at);
    obs_done_cnt  = 0;
    obs_done_lat  = -1;
    obs_ready_lat = -1;
    obs_timeout   = 1'b0;
    obs_sum       = 'x;
    obs_cout      = 1'bx;
    obs_ovf       = 1'bx;
    obs_mid_sum   = 'x;
    for (int i = 0; i < 30 && bus.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    if (bus.ready !== 1'b1) obs_timeout = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_lat < 0) begin
          obs_done_lat = e;
          obs_sum      = bus.sum;
          obs_cout     = bus.cout;
          obs_ovf      = bus.ovf;
        end
      end
      if (e == 4) obs_mid_sum = bus.sum;
      if (e == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h55;
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.ready === 1'b1 && obs_ready_lat < 0) obs_ready_lat = e;
      if (obs_ready_lat >= 0 && e > obs_ready_lat) break;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_checks++; if ({bus.sum, bus.cout, bus.ovf} !== 10'h000) begin n_fail++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 00/0/0", bus.sum, bus.cout, bus.ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL add_basic_ready_wait timed out"); end
    n_checks++; if (obs_done_lat != 8) begin n_fail++; $display("FAIL add_basic_done_latency got=%0d want=8", obs_done_lat); end
    n_checks++; if (obs_ready_lat != 9) begin n_fail++; $display("FAIL add_basic_ready_latency got=%0d want=9", obs_ready_lat); end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL add_basic_done_count got=%0d want=1", obs_done_cnt); end
    n_checks++; if (obs_sum !== 8'h10) begin n_fail++; $display("FAIL add_basic_sum got=%h want=10", obs_sum); end
    n_checks++; if ({obs_cout, obs_ovf} !== 2'b00) begin n_fail++; $display("FAIL add_basic_flags got cout=%b ovf=%b want 0/0", obs_cout, obs_ovf); end
    n_checks++; if (bus.sum !== 8'h10) begin n_fail++; $display("FAIL add_basic_sum_hold got=%h want=10", bus.sum); end
  endtask

  task automatic test_add_carry_ovf();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    n_checks++; if (obs_mid_sum !== 8'h10) begin n_fail++; $display("FAIL no_partial_sum got=%h want=10", obs_mid_sum); end
    n_checks++; if (obs_sum !== 8'h00) begin n_fail++; $display("FAIL add_wrap_sum got=%h want=00", obs_sum); end
    n_checks++; if ({obs_cout, obs_ovf} !== 2'b10) begin n_fail++; $display("FAIL add_wrap_flags got cout=%b ovf=%b want 1/0", obs_cout, obs_ovf); end
    do_op(8'h7F, 8'h00, 1'b1, 1'b0, 0);
    n_checks++; if (obs_sum !== 8'h80) begin n_fail++; $display("FAIL add_cin_ovf_sum got=%h want=80", obs_sum); end
    n_checks++; if ({obs_cout, obs_ovf} !== 2'b01) begin n_fail++; $display("FAIL add_cin_ovf_flags got cout=%b ovf=%b want 0/1", obs_cout, obs_ovf); end
  endtask

  task automatic test_sub();
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 0);
    n_checks++; if (obs_sum !== 8'hFE) begin n_fail++; $display("FAIL sub_borrow_sum got=%h want=fe", obs_sum); end
    n_checks++; if ({obs_cout, obs_ovf} !== 2'b00) begin n_fail++; $display("FAIL sub_borrow_flags got cout=%b ovf=%b want 0/0", obs_cout, obs_ovf); end
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
    n_checks++; if (obs_sum !== 8'h7F) begin n_fail++; $display("FAIL sub_ovf_sum got=%h want=7f", obs_sum); end
    n_checks++; if ({obs_cout, obs_ovf} !== 2'b11) begin n_fail++; $display("FAIL sub_ovf_flags got cout=%b ovf=%b want 1/1", obs_cout, obs_ovf); end
  endtask

  task automatic test_start_ignored();
    do_op(8'h21, 8'h13, 1'b0, 1'b0, 3);
    n_checks++; if (obs_sum !== 8'h34) begin n_fail++; $display("FAIL ignore_start_sum got=%h want=34", obs_sum); end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL ignore_start_done_count got=%0d want=1", obs_done_cnt); end
    n_checks++; if (obs_done_lat != 8) begin n_fail++; $display("FAIL ignore_start_latency got=%0d want=8", obs_done_lat); end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    logic [7:0] s_at[$];
    for (int i = 0; i < 30 && bus.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    // Accept happens at the next edge (cycle 0); dones expected at 8, 18, 28.
    for (int e = 0; e <= 35; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        done_at.push_back(e);
        s_at.push_back(bus.sum);
      end
    end
    bus.start = 1'b0;
    n_checks++; if (done_at.size() != 3) begin n_fail++; $display("FAIL b2b_done_count got=%0d want=3", done_at.size()); end
    for (int k = 0; k < done_at.size() && k < 3; k++) begin
      n_checks++; if (done_at[k] != 8 + 10 * k) begin n_fail++; $display("FAIL b2b_done_cycle[%0d] got=%0d want=%0d", k, done_at[k], 8 + 10 * k); end
      n_checks++; if (s_at[k] !== 8'h46) begin n_fail++; $display("FAIL b2b_sum[%0d] got=%h want=46", k, s_at[k]); end
    end
    for (int i = 0; i < 30 && bus.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_ready got=%b want=1", bus.ready); end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    for (int i = 0; i < 30 && bus.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL midrun_busy got ready=%b want=0", bus.ready); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.sum, bus.cout, bus.ovf} !== 10'h000) begin n_fail++; $display("FAIL midrun_reset_outputs got sum=%h cout=%b ovf=%b want 00/0/0", bus.sum, bus.cout, bus.ovf); end
    n_checks++; if ({bus.ready, bus.done} !== 2'b10) begin n_fail++; $display("FAIL midrun_reset_handshake got ready=%b done=%b want 1/0", bus.ready, bus.done); end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrun_no_done got=%0d want=0", dones); end
    do_op(8'hC8, 8'h64, 1'b0, 1'b0, 0);
    n_checks++; if (obs_sum !== 8'h2C) begin n_fail++; $display("FAIL post_reset_sum got=%h want=2c", obs_sum); end
    n_checks++; if ({obs_cout, obs_ovf} !== 2'b10) begin n_fail++; $display("FAIL post_reset_flags got cout=%b ovf=%b want 1/0", obs_cout, obs_ovf); end
    n_checks++; if (obs_done_lat != 8) begin n_fail++; $display("FAIL post_reset_latency got=%0d want=8", obs_done_lat); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add_basic();
    test_add_carry_ovf();
    test_sub();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
